pong_match_controller: RTL
==========================

Name: pong_match_controller

Overview:
- Per-frame game sequencer that owns ball motion, paddle collision, scoring and serve/game-over flow for one match.
- Replaces fixed ball coordinates: its ball_x/ball_y drive both display wrappers' XDotPosition/YDotPosition.
- Reads both paddle Y positions and advances once per frame_tick, so display fetches and physics updates stay decoupled.

Parameters:
- SCREEN_W, 640: playfield width in pixels.
- SCREEN_H, 480: playfield height in pixels.
- BALL_SIZE, 8: ball edge length in pixels (square ball).
- PADDLE_H, 80: paddle height in pixels.
- PADDLE_X1, 32: x of P1 paddle right face.
- PADDLE_X2, 608: x of P2 paddle left face.
- STEP, 4: pixels moved per axis per frame.
- SERVE_DELAY, 60: frame_ticks spent in SERVE before play.
- WIN_SCORE, 7: points needed to win.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  level; begins a match from IDLE or GAMEOVER.
- p1_y  in  11  P1 paddle top y.
- p2_y  in  11  P2 paddle top y.
- ball_x  out  11  ball top-left x.
- ball_y  out  11  ball top-left y.
- score1  out  4  P1 points.
- score2  out  4  P2 points.
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4.
- winner  out  2  0 none, 1 P1, 2 P2.
- hit  out  1  one-cycle pulse on paddle bounce.

Behaviour:
- Clock and reset: one clock domain (clock). reset_n is asynchronous and active-low.
- Reset values, any time including mid-rally:
  - ball_x=SCREEN_W/2-BALL_SIZE/2 (316), ball_y=SCREEN_H/2-BALL_SIZE/2 (236).
  - score1=score2=0, state=IDLE, winner=0, hit=0.
  - internal dx=right, dy=down, serve counter=0.
- IDLE: ball held at centre. start=1 -> SERVE (frame_tick ignored that cycle).
- SERVE:
  - Entry reloads centre position and clears the counter.
  - Counter increments on each frame_tick. When counter reaches SERVE_DELAY -> PLAY on that cycle, with no movement that tick.
- PLAY: all updates occur only on frame_tick cycles and use pre-update registered values. p1_y/p2_y are sampled that cycle.
  - Vertical, moving up: if ball_y<STEP then ball_y=0 and dy flips; else ball_y-=STEP.
  - Vertical, moving down: if ball_y+STEP>SCREEN_H-BALL_SIZE then ball_y=SCREEN_H-BALL_SIZE and dy flips; else ball_y+=STEP.
  - Vertical overlap with paddle P means ball_y+BALL_SIZE>pP_y and ball_y<pP_y+PADDLE_H.
  - Moving right, in-front test: ball_x+BALL_SIZE<=PADDLE_X2 and ball_x+BALL_SIZE+STEP>=PADDLE_X2.
    - In front and P2 overlaps: ball_x=PADDLE_X2-BALL_SIZE-1, dx flips, hit=1 next cycle.
    - Else if ball_x+BALL_SIZE+STEP>SCREEN_W: -> POINT, scorer=P1, ball position frozen.
    - Else ball_x+=STEP.
  - Moving left, in-front test: ball_x>PADDLE_X1 and ball_x<=PADDLE_X1+STEP.
    - In front and P1 overlaps: ball_x=PADDLE_X1+1, dx flips, hit.
    - Else if ball_x<STEP: -> POINT, scorer=P2.
    - Else ball_x-=STEP.
  - Horizontal and vertical updates happen in the same tick.
- POINT, single cycle:
  - Increments the scorer's score.
  - Next state: GAMEOVER if the new score==WIN_SCORE, winner set to scorer; else SERVE.
  - Next serve's dx points toward the player who lost the point; dy inverts relative to the previous serve.
- GAMEOVER: ball, scores and winner held. start=1 clears scores and winner and enters SERVE with dx=right, dy=down.
- Width and arithmetic:
  - All comparisons are done in 12-bit unsigned to avoid wrap.
  - Scores never exceed WIN_SCORE.
- hit is low except the one cycle after a bounce tick.
- start asserted in SERVE, PLAY or POINT is ignored.

Test Plan:
- Reset: reset_n low mid-PLAY -> outputs immediately 316/236, scores 0, state 0, winner 0, hit 0.
- Serve timing: start=1 then 60 frame_ticks -> state=2 after the 60th; 61st tick -> ball_x=320, ball_y=240.
- Bottom wall: continuous ticks in PLAY -> ball_y=472 at PLAY ticks 59 and 60, 468 at tick 61.
- P2 return: p2_y=400 -> 71st PLAY tick gives ball_x=599 and a hit pulse; 72nd tick gives ball_x=595.
- P2 miss: p2_y=0 -> ball_x=628 at tick 78 and 632 at tick 79; tick 80 -> POINT; next cycle score1=1, state=SERVE; the next serve moves right.
- Game over: force P1 to score 7 times -> state=4, winner=1, score1=7; ticks ignored; start -> scores 0, state=1.

Source files
------------

// File: rtl/pong_match_controller.sv
// Per-frame Pong match sequencer: ball motion, paddle bounces, scoring and the
// serve / game-over flow. Physics advances only on frame_tick.
module pong_match_controller #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_H    = 80,
  parameter int PADDLE_X1   = 32,
  parameter int PADDLE_X2   = 608,
  parameter int STEP        = 4,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 7
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [10:0] p1_y,
  input  logic [10:0] p2_y,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic [2:0]  state,
  output logic [1:0]  winner,
  output logic        hit
);
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_POINT    = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  localparam int CW = $clog2(SERVE_DELAY + 1);
  localparam logic [10:0]   CENTER_X  = 11'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [10:0]   CENTER_Y  = 11'(SCREEN_H / 2 - BALL_SIZE / 2);
  localparam logic [10:0]   STEP_11   = 11'(STEP);
  localparam logic [10:0]   Y_MAX_11  = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0]   X2_BOUNCE = 11'(PADDLE_X2 - BALL_SIZE - 1);
  localparam logic [10:0]   X1_BOUNCE = 11'(PADDLE_X1 + 1);
  localparam logic [11:0]   STEP_12   = 12'(STEP);
  localparam logic [11:0]   BALL_12   = 12'(BALL_SIZE);
  localparam logic [11:0]   PAD_H_12  = 12'(PADDLE_H);
  localparam logic [11:0]   X1_12     = 12'(PADDLE_X1);
  localparam logic [11:0]   X2_12     = 12'(PADDLE_X2);
  localparam logic [11:0]   W_12      = 12'(SCREEN_W);
  localparam logic [11:0]   Y_MAX_12  = 12'(SCREEN_H - BALL_SIZE);
  localparam logic [CW-1:0] DELAY_C   = CW'(SERVE_DELAY);
  localparam logic [3:0]    WIN_C     = 4'(WIN_SCORE);

  state_t        state_q, state_d;
  logic [10:0]   x_q, x_d, y_q, y_d;
  logic          dx_q, dx_d, dy_q, dy_d;          // dx 1 = right, dy 1 = down
  logic          serve_dy_q, serve_dy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    s1_q, s1_d, s2_q, s2_d;
  logic [1:0]    win_q, win_d;
  logic          hit_q, hit_d;
  logic          scorer_q, scorer_d;              // 0 = P1, 1 = P2

  // Widened to 12 bits so sums near the screen edge cannot wrap.
  logic [11:0] bx, by, py1, py2;
  logic        ov1, ov2, front_r, front_l;
  assign bx      = {1'b0, x_q};
  assign by      = {1'b0, y_q};
  assign py1     = {1'b0, p1_y};
  assign py2     = {1'b0, p2_y};
  assign ov1     = (by + BALL_12 > py1) && (by < py1 + PAD_H_12);
  assign ov2     = (by + BALL_12 > py2) && (by < py2 + PAD_H_12);
  assign front_r = (bx + BALL_12 <= X2_12) && (bx + BALL_12 + STEP_12 >= X2_12);
  assign front_l = (bx > X1_12) && (bx <= X1_12 + STEP_12);

  logic [10:0] nx, ny;
  logic        ndx, ndy, bounce, miss;

  always_comb begin
    nx     = x_q;
    ny     = y_q;
    ndx    = dx_q;
    ndy    = dy_q;
    bounce = 1'b0;
    miss   = 1'b0;
    if (dy_q) begin
      if (by + STEP_12 > Y_MAX_12) begin
        ny  = Y_MAX_11;
        ndy = 1'b0;
      end else ny = y_q + STEP_11;
    end else if (by < STEP_12) begin
      ny  = '0;
      ndy = 1'b1;
    end else ny = y_q - STEP_11;
    if (dx_q) begin
      if (front_r && ov2) begin
        nx     = X2_BOUNCE;
        ndx    = 1'b0;
        bounce = 1'b1;
      end else if (bx + BALL_12 + STEP_12 > W_12) miss = 1'b1;
      else nx = x_q + STEP_11;
    end else begin
      if (front_l && ov1) begin
        nx     = X1_BOUNCE;
        ndx    = 1'b1;
        bounce = 1'b1;
      end else if (bx < STEP_12) miss = 1'b1;
      else nx = x_q - STEP_11;
    end
  end

  logic [CW-1:0] cnt_inc;
  logic [3:0]    score_inc;
  assign cnt_inc   = cnt_q + CW'(1);
  assign score_inc = (scorer_q ? s2_q : s1_q) + 4'd1;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    serve_dy_d = serve_dy_q;
    cnt_d      = cnt_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    win_d      = win_q;
    hit_d      = 1'b0;
    scorer_d   = scorer_q;
    case (state_q)
      S_IDLE, S_GAMEOVER: begin
        if (start) begin
          state_d    = S_SERVE;
          x_d        = CENTER_X;
          y_d        = CENTER_Y;
          cnt_d      = '0;
          dx_d       = 1'b1;
          dy_d       = 1'b1;
          serve_dy_d = 1'b1;
          s1_d       = '0;
          s2_d       = '0;
          win_d      = '0;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DELAY_C) state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          if (miss) begin
            state_d  = S_POINT;
            scorer_d = ~dx_q;
          end else begin
            x_d   = nx;
            y_d   = ny;
            dx_d  = ndx;
            dy_d  = ndy;
            hit_d = bounce;
          end
        end
      end
      S_POINT: begin
        if (scorer_q) s2_d = score_inc;
        else          s1_d = score_inc;
        if (score_inc == WIN_C) begin
          state_d = S_GAMEOVER;
          win_d   = scorer_q ? 2'd2 : 2'd1;
        end else begin
          // Serve toward the player who just lost the point, alternating dy.
          state_d    = S_SERVE;
          x_d        = CENTER_X;
          y_d        = CENTER_Y;
          cnt_d      = '0;
          dx_d       = ~scorer_q;
          serve_dy_d = ~serve_dy_q;
          dy_d       = ~serve_dy_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      x_q        <= CENTER_X;
      y_q        <= CENTER_Y;
      dx_q       <= 1'b1;
      dy_q       <= 1'b1;
      serve_dy_q <= 1'b1;
      cnt_q      <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      win_q      <= '0;
      hit_q      <= 1'b0;
      scorer_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      serve_dy_q <= serve_dy_d;
      cnt_q      <= cnt_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      win_q      <= win_d;
      hit_q      <= hit_d;
      scorer_q   <= scorer_d;
    end
  end

  assign ball_x = x_q;
  assign ball_y = y_q;
  assign score1 = s1_q;
  assign score2 = s2_q;
  assign state  = state_q;
  assign winner = win_q;
  assign hit    = hit_q;
endmodule
